// File: rtl/mem_stage_pkg.sv
// Shared word-size defines plus the access-size and FSM encodings used by the memory stage.
`ifndef MEM_STAGE_DEFS
`define MEM_STAGE_DEFS
`define WORD_WIDTH 32
`define ZEROWORD   32'h0000_0000
`define REG_SIZE   32
`endif

package mem_stage_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

    // Little-endian lane enables; loads and stores share the same rule.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            MEM_SZ_B: be = 4'b0001 << lane;
            MEM_SZ_H: be = lane[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface mem_stage_if;
    logic                   req;
    logic                   we;
    logic [`WORD_WIDTH-1:0] addr;
    logic [3:0]             be;
    logic [`WORD_WIDTH-1:0] wdata;
    logic [`WORD_WIDTH-1:0] rdata;
    logic                   ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed lane out of a read word and sign- or zero-extends it to a full word.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [`WORD_WIDTH-1:0] rdata,
    input  logic [1:0]             lane,
    input  logic [1:0]             size,
    input  logic                   is_signed,
    output logic [`WORD_WIDTH-1:0] result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[{lane, 3'b000} +: 8];
        lane_half = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_SZ_B: result = {{24{is_signed & lane_byte[7]}}, lane_byte};
            MEM_SZ_H: result = {{16{is_signed & lane_half[15]}}, lane_half};
            default:  result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on the req/ack bus and stalls until ack or timeout.
//   state   | meaning
//   MS_IDLE | no access outstanding; misaligned ops retire here
//   MS_WAIT | request on the bus, waiting for ack or timeout
//   MS_DONE | result held for MEM/WB capture, bus idle
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   validM,
    input  logic                   memReadM,
    input  logic                   memWriteM,
    input  logic [1:0]             memSizeM,
    input  logic                   memSignedM,
    input  logic [`WORD_WIDTH-1:0] aluOutM,
    input  logic [`WORD_WIDTH-1:0] writeDataM,
    output logic [`WORD_WIDTH-1:0] readDataM,
    output logic                   stallM,
    output logic                   misalignM,
    output logic                   busErrM,
    mem_stage_if.master            dmem
);

    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

    ms_state_t              state, state_nxt;
    logic [7:0]             wait_cnt;
    logic [1:0]             lane_q;
    logic [1:0]             size_q;
    logic                   signed_q;
    logic [`WORD_WIDTH-1:0] rd_q;
    logic [`WORD_WIDTH-1:0] load_word;
    logic [`WORD_WIDTH-1:0] store_word;
    logic                   mem_op;
    logic                   access;
    logic                   timeout;

    assign mem_op    = validM & (memReadM | memWriteM);
    assign misalignM = mem_op & ((memSizeM == 2'b11)
                               | ((memSizeM == MEM_SZ_H) & aluOutM[0])
                               | ((memSizeM == MEM_SZ_W) & (aluOutM[1:0] != 2'b00)));
    assign access    = mem_op & ~misalignM;
    assign timeout   = (wait_cnt == TC_LAST);

    always_comb begin
        case (memSizeM)
            MEM_SZ_B: store_word = {4{writeDataM[7:0]}};
            MEM_SZ_H: store_word = {2{writeDataM[15:0]}};
            default:  store_word = writeDataM;
        endcase
    end

    mem_load_align u_load_align (
        .rdata     (dmem.rdata),
        .lane      (lane_q),
        .size      (size_q),
        .is_signed (signed_q),
        .result    (load_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= MS_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MS_IDLE: if (access) state_nxt = MS_WAIT;
            MS_WAIT: if (dmem.ack || timeout) state_nxt = MS_DONE;
            MS_DONE: state_nxt = MS_IDLE;
            default: state_nxt = MS_IDLE;
        endcase
    end

    always_comb begin
        stallM    = 1'b0;
        readDataM = `ZEROWORD;
        case (state)
            MS_IDLE: stallM = access;
            MS_WAIT: stallM = 1'b1;
            MS_DONE: readDataM = rd_q;
            default: stallM = 1'b0;
        endcase
        if (rst) stallM = 1'b0;
    end

    // Bus outputs stay frozen through WAIT; only req drops when the access finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= '0;
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.be    <= '0;
            dmem.wdata <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            rd_q       <= `ZEROWORD;
            busErrM    <= 1'b0;
        end else begin
            busErrM <= 1'b0;
            case (state)
                MS_IDLE: begin
                    wait_cnt <= '0;
                    if (access) begin
                        dmem.req   <= 1'b1;
                        dmem.we    <= memWriteM;
                        dmem.addr  <= {aluOutM[31:2], 2'b00};
                        dmem.be    <= lane_enables(memSizeM, aluOutM[1:0]);
                        dmem.wdata <= memWriteM ? store_word : `ZEROWORD;
                        lane_q     <= aluOutM[1:0];
                        size_q     <= memSizeM;
                        signed_q   <= memSignedM;
                    end
                end
                MS_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (dmem.ack) begin
                        dmem.req <= 1'b0;
                        rd_q     <= dmem.we ? `ZEROWORD : load_word;
                    end else if (timeout) begin
                        dmem.req <= 1'b0;
                        busErrM  <= 1'b1;
                        rd_q     <= `ZEROWORD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
